chunked_addsub_unit: RTL and testbench

Parametrised multi-cycle adder/subtractor with an internal accumulator and a valid/ready handshake on both sides. It is the successor to the team's fixed 8-bit combinational ripple adder. Operands are WIDTH bits wide and are processed CHUNK bits per clock, so area can be traded against latency. Results carry carry-out, signed-overflow and zero flags.

---
 rtl/chunked_addsub_unit.sv | 142 ++++++++++++++
 tb/tb_chunked_addsub_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_addsub_unit.sv
// chunked_addsub_unit
//   Multi-cycle adder/subtractor with an internal accumulator. Operands are
//   WIDTH bits wide and are added CHUNK bits per clock, so a result takes
//   WIDTH/CHUNK + 1 cycles from accept to out_valid. Valid/ready handshake on
//   both the request and the result side; one operation in flight at a time.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  request handshake (ready only in IDLE and out of reset)
//   a, b, op, cin   operands, opcode (00 add, 01 sub, 10 acc+a, 11 load a),
//                   carry-in / borrow-in; sampled only at the accept edge
//   out_valid/ready result handshake; results held until accepted
//   sum, cout, ovf, zero  result and flags (cout=1 means no borrow on sub)
//   acc_q           accumulator, written by op 10/11 only
module chunked_addsub_unit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [WIDTH-1:0] acc_q
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0]    K_LAST     = KW'(NCH - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic [1:0]       r_op;
  logic             r_out_valid;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  int unsigned      w_shift;
  logic [CHUNK-1:0] w_xc;
  logic [CHUNK-1:0] w_yc;
  logic [CHUNK:0]   w_csum;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_last;
  logic             w_ovf;

  // Current chunk slice of X/Y, its sum, and the result word with that chunk
  // merged in. Sub is handled at accept time (Y=~b, c0=~cin), so CALC is a
  // plain add for every opcode.
  always_comb begin
    w_shift    = 32'(r_k) * 32'(CHUNK);
    w_xc       = CHUNK'(r_x >> w_shift);
    w_yc       = CHUNK'(r_y >> w_shift);
    w_csum     = {1'b0, w_xc} + {1'b0, w_yc} + (CHUNK+1)'(r_carry);
    w_sum_next = (r_sum & ~(CHUNK_MASK << w_shift))
               | (WIDTH'(w_csum[CHUNK-1:0]) << w_shift);
    w_last     = (r_k == K_LAST);
    w_ovf      = (r_x[WIDTH-1] == r_y[WIDTH-1])
              && (w_sum_next[WIDTH-1] != r_x[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_sum       <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_k         <= '0;
      r_op        <= '0;
      r_out_valid <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            case (op)
              2'b00: begin r_x <= a;     r_y <= b;  r_carry <= cin;  end
              2'b01: begin r_x <= a;     r_y <= ~b; r_carry <= ~cin; end
              2'b10: begin r_x <= r_acc; r_y <= a;  r_carry <= 1'b0; end
              default: begin r_x <= '0;  r_y <= a;  r_carry <= 1'b0; end
            endcase
            r_op    <= op;
            r_k     <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_sum   <= w_sum_next;
          r_carry <= w_csum[CHUNK];
          r_k     <= r_k + 1'b1;
          if (w_last) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_cout      <= (r_op == 2'b11) ? 1'b0 : w_csum[CHUNK];
            r_ovf       <= (r_op == 2'b11) ? 1'b0 : w_ovf;
            r_zero      <= (w_sum_next == '0);
            if (r_op[1]) begin
              r_acc <= w_sum_next;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign acc_q     = r_acc;

endmodule

// File: tb/tb_chunked_addsub_unit.sv
// Testbench for chunked_addsub_unit: four instances with different
// (WIDTH,CHUNK) share one request/response driver. Directed table vectors
// carry hand-computed 16-bit results; the 8-bit instance and the random
// phase use a full-width reference model.
module tb_chunked_addsub_unit;

  localparam int NI = 4;
  localparam int WS[NI] = '{16, 16, 16, 8};
  localparam int CS[NI] = '{4, 16, 1, 2};

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } res_t;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    int          hold;
    bit          keep;
    bit          hand;
    logic [15:0] es;
    logic        eco;
    logic        eov;
    logic        ez;
    logic [15:0] eacc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, cin;
  logic [1:0]  op;
  logic [15:0] a, b;

  logic        irdy[NI], ovd[NI], co[NI], of[NI], zr[NI];
  logic [15:0] sm[NI], aq[NI];
  logic [7:0]  sm3, aq3;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] m_acc[NI];

  always #5 clk = ~clk;

  chunked_addsub_unit #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[0]),
    .a(a), .b(b), .op(op), .cin(cin), .out_valid(ovd[0]), .out_ready(out_ready),
    .sum(sm[0]), .cout(co[0]), .ovf(of[0]), .zero(zr[0]), .acc_q(aq[0]));

  chunked_addsub_unit #(.WIDTH(16), .CHUNK(16)) u_w16c16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[1]),
    .a(a), .b(b), .op(op), .cin(cin), .out_valid(ovd[1]), .out_ready(out_ready),
    .sum(sm[1]), .cout(co[1]), .ovf(of[1]), .zero(zr[1]), .acc_q(aq[1]));

  chunked_addsub_unit #(.WIDTH(16), .CHUNK(1)) u_w16c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[2]),
    .a(a), .b(b), .op(op), .cin(cin), .out_valid(ovd[2]), .out_ready(out_ready),
    .sum(sm[2]), .cout(co[2]), .ovf(of[2]), .zero(zr[2]), .acc_q(aq[2]));

  chunked_addsub_unit #(.WIDTH(8), .CHUNK(2)) u_w8c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[3]),
    .a(a[7:0]), .b(b[7:0]), .op(op), .cin(cin), .out_valid(ovd[3]), .out_ready(out_ready),
    .sum(sm3), .cout(co[3]), .ovf(of[3]), .zero(zr[3]), .acc_q(aq3));

  assign sm[3] = {8'h00, sm3};
  assign aq[3] = {8'h00, aq3};

  task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s [dut%0d W=%0d C=%0d] t=%0t: got 0x%0h expected 0x%0h",
               name, inst, WS[inst], CS[inst], $time, got, exp);
    end
  endtask

  // Full-width reference: one wide addition, no chunking.
  function automatic res_t ref_op(input int w, input logic [1:0] o, input logic [15:0] av,
                                  input logic [15:0] bv, input logic c, input logic [15:0] acc);
    longint unsigned mask, x, y, c0, full, s;
    res_t r;
    mask = (64'd1 << w) - 64'd1;
    case (o)
      2'b00: begin x = av & mask;  y = bv & mask;             c0 = c;  end
      2'b01: begin x = av & mask;  y = ~{48'h0, bv} & mask;   c0 = !c; end
      2'b10: begin x = acc & mask; y = av & mask;             c0 = 0;  end
      default: begin x = 0;        y = av & mask;             c0 = 0;  end
    endcase
    full = x + y + c0;
    s    = full & mask;
    r.s  = 16'(s);
    r.co = ((full >> w) & 1) != 0;
    r.ov = (((x >> (w-1)) & 1) == ((y >> (w-1)) & 1)) && (((s >> (w-1)) & 1) != ((x >> (w-1)) & 1));
    r.z  = (s == 0);
    return r;
  endfunction

  task automatic run_vec(input vec_t v);
    res_t        ex[NI];
    logic [15:0] eacc[NI];
    bit          seen[NI];
    int          lat[NI];
    logic [15:0] cs[NI], cq[NI];
    logic        cco[NI], cov[NI], cz[NI];
    bit          all;
    int          n;
    for (int i = 0; i < NI; i++) begin
      ex[i] = ref_op(WS[i], v.op, v.a, v.b, v.cin, m_acc[i]);
      if (v.hand && WS[i] == 16) begin
        ex[i] = '{s: v.es, co: v.eco, ov: v.eov, z: v.ez};
        eacc[i] = v.eacc;
      end else begin
        eacc[i] = v.op[1] ? ex[i].s : m_acc[i];
      end
      seen[i] = 0;
      lat[i]  = 0;
    end
    @(negedge clk);
    op = v.op; a = v.a; b = v.b; cin = v.cin;
    in_valid = 1'b1;
    out_ready = (v.hold == 0);
    for (int i = 0; i < NI; i++) chk("in_ready_idle", i, irdy[i], 1);
    @(negedge clk);
    if (!v.keep) in_valid = 1'b0;
    a = ~v.a; b = ~v.b; cin = ~v.cin; op = ~v.op;
    n = 1;
    all = 0;
    while (!all && n <= 64) begin
      all = 1;
      for (int i = 0; i < NI; i++) begin
        if (!seen[i] && ovd[i]) begin
          seen[i] = 1; lat[i] = n;
          cs[i] = sm[i]; cq[i] = aq[i]; cco[i] = co[i]; cov[i] = of[i]; cz[i] = zr[i];
        end
        if (!seen[i]) all = 0;
      end
      if (!all) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < NI; i++) begin
      if (!seen[i]) chk("out_valid_timeout", i, 0, 1);
      else begin
        chk("latency", i, lat[i], WS[i] / CS[i] + 1);
        chk("sum", i, cs[i], ex[i].s);
        chk("cout", i, cco[i], ex[i].co);
        chk("ovf", i, cov[i], ex[i].ov);
        chk("zero", i, cz[i], ex[i].z);
        chk("acc_q", i, cq[i], eacc[i]);
      end
    end
    if (v.hold > 0) begin
      repeat (v.hold) begin
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
          chk("hold_valid", i, ovd[i], 1);
          chk("hold_sum", i, sm[i], ex[i].s);
          chk("hold_in_ready", i, irdy[i], 0);
        end
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("valid_drop", i, ovd[i], 0);
      chk("in_ready_after", i, irdy[i], 1);
      if (v.op[1]) m_acc[i] = ex[i].s;
    end
    out_ready = 1'b1;
  endtask

  vec_t vecs[$];
  vec_t rv;
  bit   ov_seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0; op = '0; a = '0; b = '0;
    for (int i = 0; i < NI; i++) m_acc[i] = '0;

    //          op     a        b        cin hold keep hand sum      co ov z  acc
    vecs.push_back('{2'b00, 16'h1234, 16'h0FCD, 0, 0, 0, 1, 16'h2201, 0, 0, 0, 16'h0000});
    vecs.push_back('{2'b00, 16'hFFFF, 16'h0001, 0, 0, 0, 1, 16'h0000, 1, 0, 1, 16'h0000});
    vecs.push_back('{2'b01, 16'h8000, 16'h0001, 0, 0, 0, 1, 16'h7FFF, 1, 1, 0, 16'h0000});
    vecs.push_back('{2'b00, 16'h0003, 16'h0004, 0, 3, 1, 1, 16'h0007, 0, 0, 0, 16'h0000});
    vecs.push_back('{2'b01, 16'h0005, 16'h0005, 0, 0, 0, 1, 16'h0000, 1, 0, 1, 16'h0000});
    vecs.push_back('{2'b01, 16'h0000, 16'h0000, 1, 0, 0, 1, 16'hFFFF, 0, 0, 0, 16'h0000});
    vecs.push_back('{2'b00, 16'h7FFF, 16'h0000, 1, 0, 0, 1, 16'h8000, 0, 1, 0, 16'h0000});
    vecs.push_back('{2'b11, 16'h7FFF, 16'h0000, 0, 0, 0, 1, 16'h7FFF, 0, 0, 0, 16'h7FFF});
    vecs.push_back('{2'b10, 16'h0001, 16'h0000, 0, 0, 0, 1, 16'h8000, 0, 1, 0, 16'h8000});
    vecs.push_back('{2'b10, 16'h8000, 16'h0000, 0, 0, 0, 1, 16'h0000, 1, 1, 1, 16'h0000});
    vecs.push_back('{2'b11, 16'hFFFF, 16'h1234, 1, 0, 0, 1, 16'hFFFF, 0, 0, 0, 16'hFFFF});
    vecs.push_back('{2'b10, 16'h0001, 16'h5555, 1, 0, 0, 1, 16'h0000, 1, 0, 1, 16'h0000});
    vecs.push_back('{2'b11, 16'h00AA, 16'h0000, 0, 0, 0, 1, 16'h00AA, 0, 0, 0, 16'h00AA});

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_in_ready", i, irdy[i], 0);
      chk("rst_out_valid", i, ovd[i], 0);
      chk("rst_sum", i, sm[i], 0);
      chk("rst_flags", i, {co[i], of[i], zr[i]}, 0);
      chk("rst_acc", i, aq[i], 0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk("post_rst_in_ready", i, irdy[i], 1);

    foreach (vecs[j]) run_vec(vecs[j]);

    // Reset in cycle 2 of an add aborts it and clears the accumulator
    @(negedge clk);
    op = 2'b00; a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_pre_valid", 0, ovd[0], 0);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("abort_in_ready_rst", i, irdy[i], 0);
      chk("abort_acc", i, aq[i], 0);
      chk("abort_valid", i, ovd[i], 0);
    end
    rst = 1'b0;
    for (int i = 0; i < NI; i++) m_acc[i] = '0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk("abort_in_ready_after", i, irdy[i], 1);
    ov_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ovd[0] || ovd[2] || ovd[3]) ov_seen = 1;
    end
    chk("abort_no_valid", 0, ov_seen, 0);

    // Random ops across all instances against the model
    for (int j = 0; j < 150; j++) begin
      rv.op = 2'($urandom_range(0, 3));
      rv.a = 16'($urandom); rv.b = 16'($urandom); rv.cin = 1'($urandom);
      rv.hold = $urandom_range(0, 2); rv.keep = 0; rv.hand = 0;
      rv.es = '0; rv.eco = 0; rv.eov = 0; rv.ez = 0; rv.eacc = '0;
      run_vec(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
